uart_8250_tx: RTL and testbench
===============================

Name: uart_8250_tx

Overview:
Transmit serializer that sits directly downstream of the 8250 register/FIFO block. It pops bytes from the TX FIFO over a valid/ready handshake and shifts them out on TXD as asynchronous serial frames. Framing (word length, parity, stop bits, break) comes from the LCR, and bit timing comes from the divisor latch with 16x oversampling. It reports shifter-empty (TEMT) and a per-frame done pulse back to the register block for LSR/IIR updates.

Parameters:
OVERSAMPLE, 16, baud ticks per bit (fixed 16 for 8250 compatibility)
DIV_W, 16, divisor latch width (DLM:DLL)

Ports:
CLK_I  in  1  system clock
RST_I  in  1  asynchronous active-low reset
divisor  in  16  divisor latch {DLM,DLL}; 0 = transmitter halted
lcr  in  7  LCR[6:0]: [1:0] WLS, [2] STB, [3] PEN, [4] EPS, [5] stick parity, [6] break
tx_data  in  8  byte at TX FIFO head
tx_valid  in  1  TX FIFO non-empty
tx_ready  out  1  pop strobe; byte accepted when tx_valid && tx_ready
TXD  out  1  serial output, idle high
tx_empty  out  1  shifter idle (LSR.TEMT source)
frame_done  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (async, RST_I low): state IDLE, all counters 0, TXD=1, frame_done=0, tx_empty=1. tx_ready is combinational: it equals 1 after reset if divisor!=0. Reset mid-frame aborts the frame immediately, with TXD=1 asynchronously.
- tx_ready = (state==IDLE) && (divisor!=0). No acceptance while a frame is in flight and no look-ahead pop.
- Acceptance cycle:
  - Latch tx_data into the shift register and lcr[5:0] into a frame-config register.
  - LCR writes during a frame do not affect that frame. lcr[6] (break) is live, not latched.
  - Clear the baud and sub-bit counters. The next cycle enters START.
- Baud gen: cnt counts 0..divisor-1. tick asserts when cnt==divisor-1, then cnt wraps to 0. divisor==1 gives a tick every clock. If divisor becomes 0 mid-frame, ticks stop and the FSM freezes in its current state with TXD held; it resumes when divisor becomes nonzero.
- Bit timing: a 4-bit subcnt increments on each tick. A bit ends on the tick where subcnt==15, so each bit lasts 16*divisor clocks exactly.
- FSM states and TXD values:
  - IDLE: TXD=1.
  - START: TXD=0, lasts 1 bit.
  - DATA: TXD=shreg[0], LSB first, shift right per bit. Number of bits = 5+WLS (5..8). Unused upper tx_data bits are ignored.
  - PARITY: entered only if PEN.
  - STOP: TXD=1, then back to IDLE.
- Parity bit:
  - Default: XOR of the transmitted data bits, XOR ~EPS (even parity gives a total of 1s that is even).
  - Stick parity: if stick=1, the bit is ~EPS (EPS=0 gives 1, EPS=1 gives 0).
- Stop length:
  - STB=0: 16 ticks.
  - STB=1 and WLS=00: 24 ticks (1.5 bits).
  - STB=1 otherwise: 32 ticks.
  - Uses a 6-bit stop counter.
- frame_done is asserted for one cycle on the final stop tick, in the same cycle the state returns to IDLE. tx_ready is therefore 1 in the next cycle, and back-to-back frames have zero idle gap if the FIFO is non-empty.
- tx_empty = (state==IDLE).
- Break: when lcr[6]=1, TXD=0 regardless of state. The FSM keeps running, so bytes are consumed and framed invisibly, as on a real 8250. Deasserting break restores the normal TXD value on the next cycle.
- TXD is registered; there is no combinational path from tx_data to TXD.

Decomposition:
- Package uart_8250_pkg:
  - LCR bit-index constants (LCR_WLS_LO/HI, LCR_STB, LCR_PEN, LCR_EPS, LCR_STICK, LCR_BRK).
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - OVERSAMPLE constant.
  - Shared later by the receiver.
- One sub-module, uart_8250_baud_gen (divisor in, clear in, tick out), reused by the RX block for 16x sampling.

Test Plan:
- divisor=1, lcr=0x03 (8N1), push 0x55. Required response:
  - TXD=0 for 16 clocks, starting one cycle after acceptance.
  - Then 1,0,1,0,1,0,1,0 for 16 clocks each, then 1 for 16 clocks.
  - frame_done at clock 160; tx_ready high only in the acceptance cycle.
- divisor=3, lcr=0x1A (7E1), push 0x41. Required response:
  - Each bit lasts 48 clocks.
  - Data bits 1,0,0,0,0,0,1, then parity 0, then one stop.
  - Frame length 480 clocks.
- lcr=0x0C (5O, STB=1), push 0x1F. Required response:
  - Data 1,1,1,1,1, odd parity 0.
  - Stop is high for 24 ticks (1.5 bits).
  - lcr=0x2B (8, stick, EPS=0) gives parity bit 1 for any byte.
- Two bytes queued (0xA5, 0x3C) with 8N1. Required response:
  - Second start bit begins the cycle after the first frame_done, with no idle gap.
  - Changing lcr to 0x00 mid-frame leaves the first frame as 8 data bits; the second frame has 5.
- Break and reset:
  - Set lcr[6] mid-frame: TXD=0 until break clears, while frame_done still fires on schedule.
  - Assert RST_I mid-DATA: TXD=1, tx_empty=1 asynchronously.
  - After release with divisor=0: tx_ready=0 and no pop occurs despite tx_valid=1.

Source files
------------

// File: rtl/uart_8250_pkg.sv
// rtl/uart_8250_pkg.sv - shared 8250 UART constants and state types
package uart_8250_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int LCR_WLS_LO = 0;
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_STB    = 2;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_STICK  = 5;
  localparam int LCR_BRK    = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_8250_tx_if.sv
// rtl/uart_8250_tx_if.sv - TX FIFO pop handshake between register block and serializer
interface uart_8250_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_8250_baud_gen.sv
// rtl/uart_8250_baud_gen.sv - divisor-latch baud tick generator (16x oversample rate)
module uart_8250_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             clear,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divisor lowered mid-count wraps immediately
  assign tick = (divisor != '0) && (cnt >= divisor - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (divisor != '0) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_8250_tx.sv
// rtl/uart_8250_tx.sv - 8250 transmit serializer: pops TX FIFO, frames bytes onto TXD
module uart_8250_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [DIV_W-1:0] divisor,
  input  logic [6:0]       lcr,
  uart_8250_tx_if.slave    tx,
  output logic             TXD,
  output logic             tx_empty,
  output logic             frame_done
);
  import uart_8250_pkg::*;

  localparam logic [3:0] SUB_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [5:0] STOP_1   = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] STOP_15  = 6'(OVERSAMPLE * 3 / 2 - 1);
  localparam logic [5:0] STOP_2   = 6'(2 * OVERSAMPLE - 1);

  tx_state_t  state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [5:0] cfg;
  logic [3:0] subcnt, subcnt_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [5:0] stopcnt, stopcnt_n;
  logic       par, par_n;
  logic       txd_n, done_n, bit_end, accept, tick;
  logic [2:0] last_bit;
  logic [5:0] stop_last;

  assign tx.tx_ready = (state == IDLE) && (divisor != '0);
  assign accept      = tx.tx_valid && tx.tx_ready;
  assign tx_empty    = (state == IDLE);
  assign last_bit    = 3'd4 + {1'b0, cfg[LCR_WLS_HI:LCR_WLS_LO]};

  uart_8250_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (CLK_I),
    .rst_n   (RST_I),
    .divisor (divisor),
    .clear   (accept),
    .tick    (tick)
  );

  always_comb begin
    stop_last = STOP_1;
    if (cfg[LCR_STB]) begin
      stop_last = (cfg[LCR_WLS_HI:LCR_WLS_LO] == 2'b00) ? STOP_15 : STOP_2;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    subcnt_n  = subcnt;
    bitcnt_n  = bitcnt;
    stopcnt_n = stopcnt;
    par_n     = par;
    done_n    = 1'b0;
    bit_end   = tick && (subcnt == SUB_LAST);
    if (tick && state != IDLE && state != STOP) begin
      subcnt_n = subcnt + 4'd1;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = START;
          shreg_n   = tx.tx_data;
          subcnt_n  = '0;
          bitcnt_n  = '0;
          stopcnt_n = '0;
          par_n     = 1'b0;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          par_n   = par ^ shreg[0];
          shreg_n = {1'b0, shreg[7:1]};
          if (bitcnt == last_bit) begin
            state_n = cfg[LCR_PEN] ? PARITY : STOP;
          end else begin
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (tick) begin
          if (stopcnt == stop_last) begin
            state_n   = IDLE;
            stopcnt_n = '0;
            done_n    = 1'b1;
          end else begin
            stopcnt_n = stopcnt + 6'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // TXD is registered from the next state so the line changes on the bit boundary
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
      PARITY:  txd_n = cfg[LCR_STICK] ? ~cfg[LCR_EPS] : (par_n ^ ~cfg[LCR_EPS]);
      default: txd_n = 1'b1;
    endcase
    if (lcr[LCR_BRK]) txd_n = 1'b0;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state      <= IDLE;
      shreg      <= '0;
      cfg        <= '0;
      subcnt     <= '0;
      bitcnt     <= '0;
      stopcnt    <= '0;
      par        <= 1'b0;
      TXD        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      subcnt     <= subcnt_n;
      bitcnt     <= bitcnt_n;
      stopcnt    <= stopcnt_n;
      par        <= par_n;
      TXD        <= txd_n;
      frame_done <= done_n;
      if (accept) cfg <= lcr[5:0];
    end
  end

endmodule

// File: tb/tb_uart_8250_tx.sv
// tb/tb_uart_8250_tx.sv - self-checking bench for uart_8250_tx against a frame-level model
module tb_uart_8250_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] divisor;
  logic [6:0]  lcr;
  logic        txd, tx_empty, frame_done;
  int          n_tests = 0;
  int          n_fail = 0;

  uart_8250_tx_if txif();

  uart_8250_tx #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .CLK_I      (clk),
    .RST_I      (rst_n),
    .divisor    (divisor),
    .lcr        (lcr),
    .tx         (txif),
    .TXD        (txd),
    .tx_empty   (tx_empty),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sends one byte and compares every cycle of the frame against the frame built from LCR rules.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [6:0] cfg,
                           input int div, input int chg_at, input logic [6:0] chg_val,
                           input int brk_on, input int brk_off,
                           input logic nxt_valid, input logic [7:0] nxt_data, output int waited);
    int   nd, pre, stop_ticks, bl, frame_len, ones, bad_txd, early, busy;
    logic pre_bits [10];
    logic e;
    nd         = 5 + int'(cfg[1:0]);
    pre        = 1 + nd + int'(cfg[3]);
    stop_ticks = !cfg[2] ? 16 : ((cfg[1:0] == 2'b00) ? 24 : 32);
    bl         = 16 * div;
    frame_len  = pre * bl + stop_ticks * div;
    ones       = 0;
    for (int i = 0; i < 10; i++) pre_bits[i] = 1'b1;
    pre_bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      pre_bits[1 + i] = data[i];
      ones += int'(data[i]);
    end
    if (cfg[3]) begin
      if (cfg[5])      pre_bits[1 + nd] = !cfg[4];
      else if (cfg[4]) pre_bits[1 + nd] = (ones % 2) == 1;
      else             pre_bits[1 + nd] = (ones % 2) == 0;
    end
    bad_txd = 0;
    early   = 0;
    busy    = 0;
    waited  = 0;

    divisor        = 16'(div);
    lcr            = cfg;
    txif.tx_data   = data;
    txif.tx_valid  = 1'b1;
    while (!txif.tx_ready && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!txif.tx_ready) begin
      check($sformatf("%s_wait_ready", tag), 0, 1);
      return;
    end
    @(posedge clk); #1;
    txif.tx_valid = nxt_valid;
    txif.tx_data  = nxt_data;
    for (int k = 0; k <= frame_len; k++) begin
      if (k < frame_len) begin
        e = (k < pre * bl) ? pre_bits[k / bl] : 1'b1;
        if (k > brk_on && k <= brk_off) e = 1'b0;
        if (txd !== e) bad_txd++;
        if (frame_done) early++;
        if (txif.tx_ready || tx_empty) busy++;
      end else begin
        check($sformatf("%s_done", tag), int'(frame_done), 1);
        check($sformatf("%s_empty_end", tag), int'(tx_empty), 1);
        check($sformatf("%s_ready_end", tag), int'(txif.tx_ready), 1);
      end
      if (k == chg_at) lcr = chg_val;
      if (k == brk_on) lcr[6] = 1'b1;
      if (k == brk_off) lcr[6] = 1'b0;
      if (k < frame_len) begin
        @(posedge clk); #1;
      end
    end
    check($sformatf("%s_txd_bad_cycles", tag), bad_txd, 0);
    check($sformatf("%s_done_early", tag), early, 0);
    check($sformatf("%s_busy_flags", tag), busy, 0);
  endtask

  initial begin
    int w, cnt_ready, cnt_busy, cnt_low;
    rst_n         = 1'b0;
    divisor       = 16'd1;
    lcr           = 7'h03;
    txif.tx_valid = 1'b0;
    txif.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", int'(txd), 1);
    check("rst_empty", int'(tx_empty), 1);
    check("rst_done", int'(frame_done), 0);
    check("rst_ready", int'(txif.tx_ready), 1);
    rst_n = 1'b1;

    run_frame("8n1_55", 8'h55, 7'h03, 1, -1, 7'h00, -1, -1, 1'b0, 8'h00, w);
    @(posedge clk); #1;
    check("done_one_cycle", int'(frame_done), 0);

    run_frame("7e1_41", 8'h41, 7'h1A, 3, -1, 7'h00, -1, -1, 1'b0, 8'h00, w);
    run_frame("5o_stop15", 8'h1F, 7'h0C, 1, -1, 7'h00, -1, -1, 1'b0, 8'h00, w);
    run_frame("stick_00", 8'h00, 7'h2B, 2, -1, 7'h00, -1, -1, 1'b0, 8'h00, w);
    run_frame("stick_01", 8'h01, 7'h2B, 1, -1, 7'h00, -1, -1, 1'b0, 8'h00, w);

    run_frame("b2b_a5", 8'hA5, 7'h03, 1, 60, 7'h00, -1, -1, 1'b1, 8'h3C, w);
    run_frame("b2b_3c", 8'h3C, 7'h00, 1, -1, 7'h00, -1, -1, 1'b0, 8'h00, w);
    check("b2b_gap", w, 0);

    run_frame("break", 8'hC3, 7'h03, 1, -1, 7'h00, 40, 100, 1'b0, 8'h00, w);

    // Reset in the middle of the data bits of an all-zero byte
    divisor       = 16'd1;
    lcr           = 7'h03;
    txif.tx_data  = 8'h00;
    txif.tx_valid = 1'b1;
    @(posedge clk); #1;
    txif.tx_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_data_txd", int'(txd), 0);
    check("mid_data_empty", int'(tx_empty), 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_txd", int'(txd), 1);
    check("async_rst_empty", int'(tx_empty), 1);
    divisor       = 16'd0;
    txif.tx_data  = 8'hFF;
    txif.tx_valid = 1'b1;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    cnt_ready = 0;
    cnt_busy  = 0;
    cnt_low   = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (txif.tx_ready) cnt_ready++;
      if (!tx_empty) cnt_busy++;
      if (!txd) cnt_low++;
    end
    check("div0_ready", cnt_ready, 0);
    check("div0_no_pop", cnt_busy, 0);
    check("div0_txd_idle", cnt_low, 0);
    run_frame("resume_96", 8'h96, 7'h03, 1, -1, 7'h00, -1, -1, 1'b0, 8'h00, w);

    for (int i = 0; i < 12; i++) begin
      run_frame($sformatf("rnd%0d", i), 8'($urandom), 7'($urandom_range(0, 63)),
                int'($urandom_range(1, 3)), -1, 7'h00, -1, -1, 1'b0, 8'h00, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
